// File: rtl/decode_pipe_unit_if.sv
// decode_pipe_unit_if: upstream instruction handshake, flush, downstream
// ID/EX handshake and the registered decode fields of decode_pipe_unit.
// master = the surrounding pipeline / bench, slave = the decode stage.
interface decode_pipe_unit_if;
    // Upstream (IF -> ID)
    logic [31:0] instruction;
    logic        in_valid;
    logic        in_ready;
    logic        flush;

    // Downstream (ID -> EX)
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  alu_opcode;
    logic        op1_sel;
    logic        op2_sel;
    logic [1:0]  wb_sel;
    logic        regwrite_enable;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        jal_select;
    logic [2:0]  imm_select;
    logic [2:0]  funct3;
    logic        illegal;

    modport master (
        output instruction, in_valid, flush, out_ready,
        input  in_ready, out_valid, alu_opcode, op1_sel, op2_sel, wb_sel,
               regwrite_enable, mem_read, mem_write, branch, jump,
               jal_select, imm_select, funct3, illegal
    );

    modport slave (
        input  instruction, in_valid, flush, out_ready,
        output in_ready, out_valid, alu_opcode, op1_sel, op2_sel, wb_sel,
               regwrite_enable, mem_read, mem_write, branch, jump,
               jal_select, imm_select, funct3, illegal
    );
endinterface

// File: rtl/decode_pipe_unit.sv
// decode_pipe_unit: RV32I decode stage with registered ID/EX fields, a
// valid/ready handshake on both sides, a synchronous flush and a stall
// counter that holds off new instructions while EX runs a multi-cycle op.
// Optional feature macro: RV32M_EN -- decodes the M extension and enables
// the MUL/DIV stall counter; without it those encodings decode as illegal.
module decode_pipe_unit #(
    parameter int MUL_LATENCY = 1,  // EX cycles for MUL/MULH/MULHSU/MULHU, 1..15
    parameter int DIV_LATENCY = 8   // EX cycles for DIV/DIVU/REM/REMU, 1..15
) (
    input logic               CLK,
    input logic               RESETn,
    decode_pipe_unit_if.slave bus
);

    if (MUL_LATENCY < 1 || MUL_LATENCY > 15 || DIV_LATENCY < 1 || DIV_LATENCY > 15) begin : g_bad_latency
        $error("decode_pipe_unit: MUL_LATENCY and DIV_LATENCY must be in 1..15");
    end

    typedef enum logic [6:0] {
        OPC_R      = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111
    } opcode_e;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'b00000, ALU_XOR  = 5'b00001, ALU_AND  = 5'b00010,
        ALU_OR     = 5'b00011, ALU_MUL  = 5'b00100, ALU_MULH = 5'b00101,
        ALU_MULHU  = 5'b00110, ALU_MULHSU = 5'b00111, ALU_DIV = 5'b01000,
        ALU_DIVU   = 5'b01001, ALU_REM  = 5'b01010, ALU_REMU = 5'b01011,
        ALU_SLL    = 5'b01101, ALU_SRA  = 5'b01110, ALU_SLT  = 5'b01111,
        ALU_SUB    = 5'b10000, ALU_SLTU = 5'b10001, ALU_SRL  = 5'b10010
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'b000, IMM_I = 3'b001, IMM_S = 3'b010,
        IMM_B    = 3'b011, IMM_U = 3'b100, IMM_J = 3'b101
    } imm_sel_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00, WB_MEM = 2'b01, WB_PC4 = 2'b10
    } wb_sel_e;

    typedef struct packed {
        alu_op_e  alu_opcode;
        logic     op1_sel;          // 0 = rs1, 1 = PC
        logic     op2_sel;          // 0 = rs2, 1 = immediate
        wb_sel_e  wb_sel;
        logic     regwrite_enable;
        logic     mem_read;
        logic     mem_write;
        logic     branch;
        logic     jump;
        logic     jal_select;
        imm_sel_e imm_select;
        logic [2:0] funct3;
        logic     illegal;
    } dec_t;

    // Shared funct3 table of the base register/immediate ALU group.
    function automatic alu_op_e base_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    dec_t       dec_d;
    dec_t       dec_q;
    logic       out_valid_q;
    logic [3:0] stall_cnt_q;
    logic       in_ready;
    logic       accept;

    assign opcode = bus.instruction[6:0];
    assign f3     = bus.instruction[14:12];
    assign f7     = bus.instruction[31:25];

`ifdef RV32M_EN
    logic is_mul_d;
    logic is_div_d;
`endif

    // Combinational decode of the instruction presented upstream.
    always_comb begin
        // NOTE: every field gets a default before the case tree so no path
        // leaves a variable unassigned, which would infer a latch.
        dec_d        = '0;
        dec_d.funct3 = f3;
`ifdef RV32M_EN
        is_mul_d = 1'b0;
        is_div_d = 1'b0;
`endif
        case (opcode)
            OPC_R: begin
                dec_d.regwrite_enable = 1'b1;
                case (f7)
                    7'b0000000: dec_d.alu_opcode = base_alu(f3);
                    7'b0100000: begin
                        if (f3 == 3'b000)      dec_d.alu_opcode = ALU_SUB;
                        else if (f3 == 3'b101) dec_d.alu_opcode = ALU_SRA;
                        else                   dec_d.illegal    = 1'b1;
                    end
`ifdef RV32M_EN
                    7'b0000001: begin
                        case (f3)
                            3'b000:  dec_d.alu_opcode = ALU_MUL;
                            3'b001:  dec_d.alu_opcode = ALU_MULH;
                            3'b010:  dec_d.alu_opcode = ALU_MULHSU;
                            3'b011:  dec_d.alu_opcode = ALU_MULHU;
                            3'b100:  dec_d.alu_opcode = ALU_DIV;
                            3'b101:  dec_d.alu_opcode = ALU_DIVU;
                            3'b110:  dec_d.alu_opcode = ALU_REM;
                            default: dec_d.alu_opcode = ALU_REMU;
                        endcase
                        is_mul_d = ~f3[2];
                        is_div_d = f3[2];
                    end
`endif
                    default: dec_d.illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                dec_d.alu_opcode      = base_alu(f3);
                dec_d.op2_sel         = 1'b1;
                dec_d.imm_select      = IMM_I;
                dec_d.regwrite_enable = 1'b1;
                // Shift immediates reuse funct7 as a selector; other funct7
                // patterns are not valid RV32 shifts.
                if (f3 == 3'b001 && f7 != 7'b0000000) begin
                    dec_d.illegal = 1'b1;
                end else if (f3 == 3'b101) begin
                    if (f7 == 7'b0100000)      dec_d.alu_opcode = ALU_SRA;
                    else if (f7 != 7'b0000000) dec_d.illegal    = 1'b1;
                end
            end
            OPC_LOAD: begin
                dec_d.op2_sel         = 1'b1;
                dec_d.imm_select      = IMM_I;
                dec_d.wb_sel          = WB_MEM;
                dec_d.mem_read        = 1'b1;
                dec_d.regwrite_enable = 1'b1;
                dec_d.illegal         = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                dec_d.op2_sel    = 1'b1;
                dec_d.imm_select = IMM_S;
                dec_d.mem_write  = 1'b1;
                dec_d.illegal    = f3[2] || (f3 == 3'b011);
            end
            OPC_BRANCH: begin
                dec_d.op1_sel    = 1'b1;
                dec_d.op2_sel    = 1'b1;
                dec_d.imm_select = IMM_B;
                dec_d.branch     = 1'b1;
                dec_d.illegal    = (f3[2:1] == 2'b01);
            end
            OPC_JAL: begin
                dec_d.op1_sel         = 1'b1;
                dec_d.op2_sel         = 1'b1;
                dec_d.imm_select      = IMM_J;
                dec_d.wb_sel          = WB_PC4;
                dec_d.jump            = 1'b1;
                dec_d.jal_select      = 1'b1;
                dec_d.regwrite_enable = 1'b1;
            end
            OPC_JALR: begin
                dec_d.op2_sel         = 1'b1;
                dec_d.imm_select      = IMM_I;
                dec_d.wb_sel          = WB_PC4;
                dec_d.jump            = 1'b1;
                dec_d.regwrite_enable = 1'b1;
                dec_d.illegal         = (f3 != 3'b000);
            end
            OPC_LUI: begin
                // op1 stays on rs1; EX substitutes zero for LUI.
                dec_d.op2_sel         = 1'b1;
                dec_d.imm_select      = IMM_U;
                dec_d.regwrite_enable = 1'b1;
            end
            OPC_AUIPC: begin
                dec_d.op1_sel         = 1'b1;
                dec_d.op2_sel         = 1'b1;
                dec_d.imm_select      = IMM_U;
                dec_d.regwrite_enable = 1'b1;
            end
            default: dec_d.illegal = 1'b1;
        endcase

        // An illegal instruction still flows downstream but must not have
        // any architectural side effect.
        if (dec_d.illegal) begin
            dec_d.regwrite_enable = 1'b0;
            dec_d.mem_read        = 1'b0;
            dec_d.mem_write       = 1'b0;
            dec_d.branch          = 1'b0;
            dec_d.jump            = 1'b0;
        end
    end

    assign in_ready = (!out_valid_q || bus.out_ready) && (stall_cnt_q == 4'd0) && !bus.flush;
    assign accept   = bus.in_valid && in_ready;

    // Output register: load on accept, drop valid on drain, flush wins.
    always_ff @(posedge CLK or negedge RESETn) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples pre-edge values regardless of block order.
        if (!RESETn) begin
            dec_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            dec_q       <= dec_d;
            out_valid_q <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef RV32M_EN
    localparam logic [3:0] MUL_STALL = 4'(MUL_LATENCY - 1);
    localparam logic [3:0] DIV_STALL = 4'(DIV_LATENCY - 1);

    // Stall counter: loads on an accepted M op, counts down to zero.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            stall_cnt_q <= 4'd0;
        end else if (bus.flush) begin
            stall_cnt_q <= 4'd0;
        end else if (accept && is_mul_d) begin
            stall_cnt_q <= MUL_STALL;
        end else if (accept && is_div_d) begin
            stall_cnt_q <= DIV_STALL;
        end else if (stall_cnt_q != 4'd0) begin
            stall_cnt_q <= stall_cnt_q - 4'd1;
        end
    end
`else
    // Without the M extension nothing ever stalls.
    assign stall_cnt_q = 4'd0;
`endif

    assign bus.in_ready        = in_ready;
    assign bus.out_valid       = out_valid_q;
    assign bus.alu_opcode      = dec_q.alu_opcode;
    assign bus.op1_sel         = dec_q.op1_sel;
    assign bus.op2_sel         = dec_q.op2_sel;
    assign bus.wb_sel          = dec_q.wb_sel;
    assign bus.regwrite_enable = dec_q.regwrite_enable;
    assign bus.mem_read        = dec_q.mem_read;
    assign bus.mem_write       = dec_q.mem_write;
    assign bus.branch          = dec_q.branch;
    assign bus.jump            = dec_q.jump;
    assign bus.jal_select      = dec_q.jal_select;
    assign bus.imm_select      = dec_q.imm_select;
    assign bus.funct3          = dec_q.funct3;
    assign bus.illegal         = dec_q.illegal;

endmodule

// File: tb/tb_decode_pipe_unit.sv
// tb_decode_pipe_unit: directed and random instructions through
// decode_pipe_unit, checked against a mnemonic-level reference decoder.
// Honours RV32M_EN the same way the design does.
module tb_decode_pipe_unit;

    localparam int MUL_LAT  = 1;
    localparam int DIV_LAT  = 8;
    localparam int WAIT_MAX = 40;
`ifdef RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    localparam logic [6:0] OPC_TAB [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                            7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
    localparam logic [6:0] F7_TAB [4]   = '{7'h00, 7'h20, 7'h01, 7'h55};

    typedef struct {
        logic [4:0] alu;
        logic       op1, op2;
        logic [1:0] wb;
        logic       rw, mr, mw, br, jp, js;
        logic [2:0] imm, f3;
        logic       ill;
        int         stall;
    } exp_t;

    logic CLK;
    logic RESETn;
    int   checks = 0;
    int   errors = 0;

    decode_pipe_unit_if bus ();

    decode_pipe_unit #(
        .MUL_LATENCY (MUL_LAT),
        .DIV_LATENCY (DIV_LAT)
    ) dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference decoder (mnemonic level) ----------------
    function automatic string base_name(input logic [2:0] f3);
        case (f3)
            3'd0: return "add";  3'd1: return "sll";  3'd2: return "slt";
            3'd3: return "sltu"; 3'd4: return "xor";  3'd5: return "srl";
            3'd6: return "or";   default: return "and";
        endcase
    endfunction

    function automatic string m_name(input logic [2:0] f3);
        case (f3)
            3'd0: return "mul";  3'd1: return "mulh"; 3'd2: return "mulhsu";
            3'd3: return "mulhu"; 3'd4: return "div"; 3'd5: return "divu";
            3'd6: return "rem";  default: return "remu";
        endcase
    endfunction

    function automatic logic [4:0] alu_code(input string m);
        case (m)
            "add": return 5'd0;   "xor": return 5'd1;    "and": return 5'd2;
            "or": return 5'd3;    "mul": return 5'd4;    "mulh": return 5'd5;
            "mulhu": return 5'd6; "mulhsu": return 5'd7; "div": return 5'd8;
            "divu": return 5'd9;  "rem": return 5'd10;   "remu": return 5'd11;
            "sll": return 5'd13;  "sra": return 5'd14;   "slt": return 5'd15;
            "sub": return 5'd16;  "sltu": return 5'd17;  "srl": return 5'd18;
            default: return 5'd0;
        endcase
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] ins);
        exp_t       e;
        string      m   = "";
        byte        fmt = "X";
        logic [6:0] opc = ins[6:0];
        logic [2:0] f3  = ins[14:12];
        logic [6:0] f7  = ins[31:25];
        e = '{default: '0};
        e.f3 = f3;
        case (opc)
            7'h33: begin
                fmt = "R";
                if (f7 == 7'h00)                    m = base_name(f3);
                else if (f7 == 7'h20 && f3 == 3'd0) m = "sub";
                else if (f7 == 7'h20 && f3 == 3'd5) m = "sra";
                else if (f7 == 7'h01 && M_EN)       m = m_name(f3);
            end
            7'h13: begin
                fmt = "I";
                if (f3 == 3'd1)      m = (f7 == 7'h00) ? "sll" : "";
                else if (f3 == 3'd5) m = (f7 == 7'h00) ? "srl" : (f7 == 7'h20) ? "sra" : "";
                else                 m = base_name(f3);
            end
            7'h03: begin fmt = "L"; m = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ? "add" : ""; end
            7'h23: begin fmt = "S"; m = (f3 <= 3'd2) ? "add" : ""; end
            7'h63: begin fmt = "B"; m = (f3 != 3'd2 && f3 != 3'd3) ? "add" : ""; end
            7'h6F: begin fmt = "J"; m = "add"; end
            7'h67: begin fmt = "j"; m = (f3 == 3'd0) ? "add" : ""; end
            7'h37: begin fmt = "U"; m = "add"; end
            7'h17: begin fmt = "A"; m = "add"; end
            default: m = "";
        endcase
        if (m == "") begin
            e.ill = 1'b1;
            return e;
        end
        e.alu = alu_code(m);
        case (m)
            "mul", "mulh", "mulhsu", "mulhu": e.stall = MUL_LAT - 1;
            "div", "divu", "rem", "remu":     e.stall = DIV_LAT - 1;
            default:                          e.stall = 0;
        endcase
        case (fmt)
            "R": e.rw = 1;
            "I": begin e.op2 = 1; e.imm = 3'd1; e.rw = 1; end
            "L": begin e.op2 = 1; e.imm = 3'd1; e.wb = 2'd1; e.mr = 1; e.rw = 1; end
            "S": begin e.op2 = 1; e.imm = 3'd2; e.mw = 1; end
            "B": begin e.op1 = 1; e.op2 = 1; e.imm = 3'd3; e.br = 1; end
            "J": begin e.op1 = 1; e.op2 = 1; e.imm = 3'd5; e.wb = 2'd2; e.jp = 1; e.js = 1; e.rw = 1; end
            "j": begin e.op2 = 1; e.imm = 3'd1; e.wb = 2'd2; e.jp = 1; e.rw = 1; end
            "U": begin e.op2 = 1; e.imm = 3'd4; e.rw = 1; end
            "A": begin e.op1 = 1; e.op2 = 1; e.imm = 3'd4; e.rw = 1; end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] exp_fields(input exp_t e);
        return 32'({e.alu, e.op1, e.op2, e.wb, e.rw, e.mr, e.mw, e.br, e.jp, e.js, e.imm, e.f3, e.ill});
    endfunction

    function automatic logic [31:0] obs_fields();
        return 32'({bus.alu_opcode, bus.op1_sel, bus.op2_sel, bus.wb_sel, bus.regwrite_enable,
                    bus.mem_read, bus.mem_write, bus.branch, bus.jump, bus.jal_select,
                    bus.imm_select, bus.funct3, bus.illegal});
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        w[6:0]   = OPC_TAB[$urandom_range(9, 0)];
        w[31:25] = F7_TAB[$urandom_range(3, 0)];
        return w;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Present an instruction, wait (bounded) for acceptance, return just
    // after the negedge following the transfer edge with in_valid low.
    task automatic push(input logic [31:0] ins, input logic ordy);
        int w = 0;
        @(negedge CLK);
        bus.instruction = ins;
        bus.in_valid    = 1'b1;
        bus.out_ready   = ordy;
        #1;
        while (!bus.in_ready && w < WAIT_MAX) begin
            @(negedge CLK);
            #1;
            w++;
        end
        check("accept_wait", 32'(w < WAIT_MAX), 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        bus.in_valid = 1'b0;
        #1;
    endtask

    // Full transaction: decode fields, then the number of stall cycles.
    task automatic issue(input logic [31:0] ins);
        exp_t e = ref_decode(ins);
        int   n = 0;
        push(ins, 1'b1);
        check("out_valid", 32'(bus.out_valid), 32'd1);
        check("illegal_and_enables",
              32'({bus.illegal, bus.regwrite_enable, bus.mem_read, bus.mem_write, bus.branch, bus.jump}),
              32'({e.ill, e.rw, e.mr, e.mw, e.br, e.jp}));
        if (!e.ill) check("fields", obs_fields(), exp_fields(e));
        while (!bus.in_ready && n < 20) begin
            @(negedge CLK);
            #1;
            n++;
        end
        check("stall_cycles", 32'(n), 32'(e.stall));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        exp_t e;
        RESETn          = 1'b0;
        bus.instruction = 32'h0;
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b1;
        bus.flush       = 1'b0;

        // Reset state
        repeat (3) @(negedge CLK);
        #1;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_fields", obs_fields(), 32'd0);
        @(negedge CLK);
        RESETn = 1'b1;
        #1;
        check("ready_after_reset", 32'(bus.in_ready), 32'd1);

        // add x0,x1,x2
        issue(32'h00208033);

        // Hold with out_ready low, then drain and accept together
        push(32'hFFF00093, 1'b0);
        e = ref_decode(32'hFFF00093);
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_ready", 32'(bus.in_ready), 32'd0);
        check("hold_fields0", obs_fields(), exp_fields(e));
        repeat (3) @(negedge CLK);
        #1;
        check("hold_fields3", obs_fields(), exp_fields(e));
        check("hold_valid3", 32'(bus.out_valid), 32'd1);
        @(negedge CLK);
        bus.instruction = 32'h40208033;
        bus.in_valid    = 1'b1;
        bus.out_ready   = 1'b1;
        #1;
        check("drain_accept_ready", 32'(bus.in_ready), 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        bus.in_valid = 1'b0;
        #1;
        check("drain_accept_valid", 32'(bus.out_valid), 32'd1);
        check("drain_accept_fields", obs_fields(), exp_fields(ref_decode(32'h40208033)));
        @(negedge CLK);

        // One of each class plus illegal funct combinations and M ops
        issue(32'h0000A083);  // lw
        issue(32'h0020A023);  // sw
        issue(32'h00208063);  // beq
        issue(32'h008000EF);  // jal
        issue(32'h000080E7);  // jalr
        issue(32'h123450B7);  // lui
        issue(32'h00001097);  // auipc
        issue(32'h4010D093);  // srai
        issue(32'h40109093);  // slli with bad funct7
        issue(32'h0000B083);  // load funct3 011
        issue(32'h0000007F);  // unknown opcode
        issue(32'h022080B3);  // mul
        issue(32'h0220C033);  // div
        issue(32'h0220F0B3);  // remu
        issue(32'h0220C033);  // back-to-back divide

        // Flush four cycles into a divide, with a competing input
        push(32'h0220C033, 1'b1);
        bus.out_ready = 1'b0;
        repeat (3) @(negedge CLK);
        bus.flush       = 1'b1;
        bus.in_valid    = 1'b1;
        bus.instruction = 32'h00100093;
        #1;
        check("flush_blocks_ready", 32'(bus.in_ready), 32'd0);
        @(negedge CLK);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        check("flush_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;

        // Reset in the middle of a stall aborts it without a clock edge
        push(32'h0220C033, 1'b1);
        #2;
        RESETn = 1'b0;
        #1;
        check("async_reset_valid", 32'(bus.out_valid), 32'd0);
        check("async_reset_fields", obs_fields(), 32'd0);
        check("async_reset_ready", 32'(bus.in_ready), 32'd1);
        @(negedge CLK);
        RESETn = 1'b1;
        #1;
        check("ready_after_rereset", 32'(bus.in_ready), 32'd1);

        // Random instructions
        for (int i = 0; i < 60; i++) begin
            issue(rand_instr());
            repeat ($urandom_range(1, 0)) @(negedge CLK);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
